or_force_sched: RTL and testbench
=================================

OR_FORCE_SCHED -- requirements
Module: or_force_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 2, meaning the bit width of the OR datapath and the force value.
REQ-002 SHALL have parameter NREQ, default 4, meaning the number of force requesters (2..8).
REQ-003 SHALL have parameter CNT_W, default 8, meaning the bit width of the force-duration field.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset; it is synchronous and active-high.
REQ-006 SHALL have port a_in, input, WIDTH, meaning OR datapath operand A.
REQ-007 SHALL have port b_in, input, WIDTH, meaning OR datapath operand B.
REQ-008 SHALL have port req, input, NREQ, meaning a per-requester force request level.
REQ-009 SHALL have port req_val, input, NREQ*WIDTH, meaning the per-requester force value; requester i occupies slice [i*WIDTH +: WIDTH].
REQ-010 SHALL have port req_dur, input, NREQ*CNT_W, meaning the per-requester force duration in cycles, packed the same way.
REQ-011 SHALL have port grant, output, NREQ, meaning a one-hot indicator of the current owner; it is held for the whole force window.
REQ-012 SHALL have port done, output, NREQ, meaning a one-cycle pulse to the owner on release.
REQ-013 SHALL have port data_out, output, WIDTH, meaning the registered datapath output.
REQ-014 SHALL have port forcing, output, 1, meaning data_out currently carries a forced value.

Function
REQ-015 SHALL update data_out every cycle: next value = forced value when in FORCE state, else a_in | b_in bitwise; latency is 1 cycle.
REQ-016 SHALL implement FSM states IDLE, FORCE and RELEASE.
REQ-017 In IDLE with any req bit set, SHALL select one requester round-robin starting at pointer rr_ptr.
REQ-018 On selection, SHALL latch that requester's req_val and req_dur, assert its grant bit, and enter FORCE on the next edge.
REQ-019 SHALL treat a req_dur of 0 as 1.
REQ-020 In FORCE, SHALL hold data_out at the latched value for exactly the latched duration in cycles, counting down from it.
REQ-021 SHALL ignore req_val and req_dur changes after the latch.
REQ-022 SHALL leave FORCE when the count reaches 1, or early if the owner deasserts req (abort), taking effect the next cycle.
REQ-023 RELEASE SHALL last one cycle.
REQ-024 In RELEASE: grant SHALL be cleared, done[owner] pulsed, data_out return to a_in|b_in, and rr_ptr set to owner+1 modulo NREQ.
REQ-025 RELEASE SHALL always proceed to IDLE; back-to-back grants are therefore separated by at least one unforced cycle.
REQ-026 forcing SHALL be high exactly in the cycles where data_out holds a forced value.
REQ-027 Requests arriving during FORCE or RELEASE SHALL wait; no request is lost while its req stays high.
REQ-028 If several req bits rise together, SHALL grant the first set bit at or after rr_ptr, wrapping from NREQ-1 to 0.

Reset
REQ-029 With rst high at a clock edge, SHALL set: state IDLE, rr_ptr 0, grant 0, done 0, forcing 0, data_out 0, counter 0.
REQ-030 Reset asserted mid-FORCE SHALL abort without a done pulse; the first unforced output appears one cycle after rst falls.

Structure
REQ-031 SHALL place the FSM state enum (IDLE, FORCE, RELEASE) in shared package or_fr_pkg.
REQ-032 SHALL implement the round-robin selection as sub-module rr_pick, parameterised by NREQ, taking req and rr_ptr and returning a one-hot grant and a valid flag; it is combinational.

Verification
REQ-033 SHALL test: no req, a_in=2'b01, b_in=2'b10 -> data_out=2'b11 one cycle later; forcing=0.
REQ-034 SHALL test: req[1] held, val=2'b00, dur=3 -> grant=4'b0010; data_out=2'b00 for exactly 3 cycles; done[1] pulses once; data_out returns to a|b.
REQ-035 SHALL test: req=4'b1111 held, all dur=1 -> grants in order 0,1,2,3,0 with one release cycle between each.
REQ-036 SHALL test: req[2], dur=10, req[2] dropped after 4 forced cycles -> RELEASE in the following cycle; done[2] pulses; rr_ptr=3.
REQ-037 SHALL test: dur=0 -> exactly one forced cycle.
REQ-038 SHALL test: rst pulsed during FORCE -> all outputs 0, no done pulse; first grant afterwards goes to requester 0.

Source files
------------

// File: rtl/or_fr_pkg.sv
// Shared definitions for the OR datapath with round-robin value forcing.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Contents: FSM state encoding, pointer-width helper.
package or_fr_pkg;

   // Owner lifecycle: wait for a request, hold the forced value, hand back.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FORCE   = 2'd1,
      RELEASE = 2'd2
   } fr_state_e;

   // Width of a requester index; never zero even for a single requester.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping to 0.
// Latency: combinational.
// Backpressure: none; the caller decides when to act on the pick.
// Ports: req_i request levels, ptr_i search start, gnt_o one-hot pick, vld_o any request.
module rr_pick
   import or_fr_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int PTR_W = ptr_width(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic             vld_o
);

   logic [NREQ-1:0] hi_mask;
   logic [NREQ-1:0] req_hi;

   always_comb begin
      // Bits at or above the pointer get first chance; if none of them
      // is set, the lowest set bit overall is the wrapped winner.
      hi_mask = ~((NREQ'(1) << ptr_i) - NREQ'(1));
      req_hi  = req_i & hi_mask;
      if (|req_hi) begin
         gnt_o = req_hi & (-req_hi);
      end else begin
         gnt_o = req_i & (-req_i);
      end
      vld_o = |req_i;
   end

endmodule

// File: rtl/or_force_sched.sv
// Registered OR datapath whose output can be overridden by one requester at a time.
// Latency: 1 cycle from a_in/b_in or a granted request to data_out.
// Backpressure: requests are levels; a waiting requester holds req until granted.
// Ports: clk/rst (sync, active-high); a_in,b_in operands; req/req_val/req_dur per
//        requester; grant one-hot owner; done release pulse; data_out; forcing flag.
module or_force_sched
   import or_fr_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int NREQ  = 4,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       a_in,
   input  logic [WIDTH-1:0]       b_in,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*WIDTH-1:0]  req_val,
   input  logic [NREQ*CNT_W-1:0]  req_dur,
   output logic [NREQ-1:0]        grant,
   output logic [NREQ-1:0]        done,
   output logic [WIDTH-1:0]       data_out,
   output logic                   forcing
);

   localparam int PTR_W = ptr_width(NREQ);

   fr_state_e           state_q;
   logic [PTR_W-1:0]    rr_ptr_q;
   logic [PTR_W-1:0]    owner_q;
   logic [WIDTH-1:0]    val_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [NREQ-1:0]     grant_q;
   logic [NREQ-1:0]     done_q;
   logic [WIDTH-1:0]    data_out_q;
   logic                forcing_q;

   logic [NREQ-1:0]     pick_gnt;
   logic                pick_vld;
   logic [PTR_W-1:0]    pick_idx_d;
   logic [WIDTH-1:0]    pick_val_d;
   logic [CNT_W-1:0]    pick_dur_d;
   logic [PTR_W-1:0]    rr_ptr_d;
   logic [WIDTH-1:0]    or_d;
   logic                release_d;

   rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req_i (req),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .vld_o (pick_vld)
   );

   always_comb begin
      pick_idx_d = '0;
      pick_val_d = '0;
      pick_dur_d = '0;
      // Mux the winner's index, value and duration out of the packed buses.
      for (int i = 0; i < NREQ; i++) begin
         if (pick_gnt[i]) begin
            pick_idx_d = PTR_W'(i);
            pick_val_d = req_val[i*WIDTH +: WIDTH];
            pick_dur_d = req_dur[i*CNT_W +: CNT_W];
         end
      end
      // A zero duration still gives the owner one forced cycle.
      if (pick_dur_d == '0) begin
         pick_dur_d = CNT_W'(1);
      end
      rr_ptr_d = (owner_q == PTR_W'(NREQ-1)) ? '0 : owner_q + PTR_W'(1);
      or_d     = a_in | b_in;
      // Window ends on the last counted cycle, or early when the owner lets go.
      release_d = (cnt_q == CNT_W'(1)) || !req[owner_q];
   end

   // Outputs are loaded from the state being entered, so forcing and the
   // forced data_out line up exactly with the FORCE cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         val_q      <= '0;
         cnt_q      <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         data_out_q <= '0;
         forcing_q  <= 1'b0;
      end else begin
         done_q     <= '0;
         data_out_q <= or_d;
         forcing_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_vld) begin
                  state_q    <= FORCE;
                  owner_q    <= pick_idx_d;
                  val_q      <= pick_val_d;
                  cnt_q      <= pick_dur_d;
                  grant_q    <= pick_gnt;
                  data_out_q <= pick_val_d;
                  forcing_q  <= 1'b1;
               end
            end
            FORCE: begin
               if (release_d) begin
                  state_q  <= RELEASE;
                  grant_q  <= '0;
                  done_q   <= grant_q;
                  rr_ptr_q <= rr_ptr_d;
                  cnt_q    <= '0;
               end else begin
                  cnt_q      <= cnt_q - CNT_W'(1);
                  data_out_q <= val_q;
                  forcing_q  <= 1'b1;
               end
            end
            RELEASE: begin
               // Always pass through IDLE so grants never abut.
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign grant    = grant_q;
   assign done     = done_q;
   assign data_out = data_out_q;
   assign forcing  = forcing_q;

endmodule

// File: tb/tb_or_force_sched.sv
// Directed bench for or_force_sched with hand-computed per-cycle expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Observation vector per cycle is {grant, done, forcing, data_out}.
module tb_or_force_sched;
   localparam int WIDTH = 2;
   localparam int NREQ  = 4;
   localparam int CNT_W = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [WIDTH-1:0]      a_in, b_in;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_val;
   logic [NREQ*CNT_W-1:0] req_dur;
   logic [NREQ-1:0]       grant, done;
   logic [WIDTH-1:0]      data_out;
   logic                  forcing;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   or_force_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .a_in     (a_in),
      .b_in     (b_in),
      .req      (req),
      .req_val  (req_val),
      .req_dur  (req_dur),
      .grant    (grant),
      .done     (done),
      .data_out (data_out),
      .forcing  (forcing)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [WIDTH-1:0] v, input logic [CNT_W-1:0] d);
      req_val[i*WIDTH +: WIDTH] = v;
      req_dur[i*CNT_W +: CNT_W] = d;
   endtask

   task automatic test_reset;
      logic [10:0] obs;
      rst = 1'b1; a_in = 2'b11; b_in = 2'b11; req = 4'b1111;
      for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, 8'd2);
      for (int c = 0; c < 2; c++) begin
         tick;
         obs = {grant, done, forcing, data_out};
         checks++;
         if (obs !== 11'b0) begin
            errors++;
            $display("FAIL reset c%0d got %b exp %b", c, obs, 11'b0);
         end
      end
      req = '0;
      rst = 1'b0;
   endtask

   task automatic test_or_path;
      logic [WIDTH-1:0] av [3] = '{2'b01, 2'b00, 2'b10};
      logic [WIDTH-1:0] bv [3] = '{2'b10, 2'b00, 2'b00};
      logic [WIDTH-1:0] ev [3] = '{2'b11, 2'b00, 2'b10};
      logic [10:0] obs, exp;
      for (int k = 0; k < 3; k++) begin
         a_in = av[k]; b_in = bv[k];
         tick;
         obs = {grant, done, forcing, data_out};
         exp = {4'b0, 4'b0, 1'b0, ev[k]};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL or_path k%0d got %b exp %b", k, obs, exp);
         end
      end
   endtask

   // Requester 1, value 00, duration 3; value/duration rewritten mid-window.
   task automatic test_force_basic;
      logic [10:0] obs, exp;
      a_in = 2'b11; b_in = 2'b11;
      set_req(1, 2'b00, 8'd3);
      req = 4'b0010;
      for (int c = 1; c <= 6; c++) begin
         tick;
         if (c <= 3)      exp = {4'b0010, 4'b0000, 1'b1, 2'b00};
         else if (c == 4) exp = {4'b0000, 4'b0010, 1'b0, 2'b11};
         else             exp = {4'b0000, 4'b0000, 1'b0, 2'b11};
         obs = {grant, done, forcing, data_out};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL force_basic c%0d got %b exp %b", c, obs, exp);
         end
         if (c == 1) set_req(1, 2'b11, 8'd1);
         if (c == 4) req = '0;
      end
   endtask

   // Requester 2, duration 10, req dropped once 4 forced cycles have been seen.
   task automatic test_abort;
      logic [10:0] obs, exp;
      a_in = 2'b10; b_in = 2'b00;
      set_req(2, 2'b01, 8'd10);
      req = 4'b0100;
      for (int c = 1; c <= 6; c++) begin
         tick;
         if (c <= 4)      exp = {4'b0100, 4'b0000, 1'b1, 2'b01};
         else if (c == 5) exp = {4'b0000, 4'b0100, 1'b0, 2'b10};
         else             exp = {4'b0000, 4'b0000, 1'b0, 2'b10};
         obs = {grant, done, forcing, data_out};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL abort c%0d got %b exp %b", c, obs, exp);
         end
         if (c == 4) req = '0;
      end
      // Pointer should now be 3: all-requesters picks requester 3.
      for (int i = 0; i < NREQ; i++) set_req(i, 2'b11, 8'd1);
      req = 4'b1111;
      for (int c = 1; c <= 3; c++) begin
         tick;
         if (c == 1)      exp = {4'b1000, 4'b0000, 1'b1, 2'b11};
         else if (c == 2) exp = {4'b0000, 4'b1000, 1'b0, 2'b10};
         else             exp = {4'b0000, 4'b0000, 1'b0, 2'b10};
         obs = {grant, done, forcing, data_out};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL abort_ptr c%0d got %b exp %b", c, obs, exp);
         end
         if (c == 1) req = '0;
      end
   endtask

   // All four requesting, duration 1: grant / release / idle repeating, owners 0,1,2,3,0.
   task automatic test_round_robin;
      logic [10:0]     obs, exp;
      logic [NREQ-1:0] oh;
      int              owner;
      a_in = 2'b11; b_in = 2'b00;
      for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(i), 8'd1);
      req = 4'b1111;
      for (int k = 0; k < 13; k++) begin
         tick;
         owner = (k / 3) % NREQ;
         oh = NREQ'(1) << owner;
         case (k % 3)
            0:       exp = {oh, 4'b0000, 1'b1, WIDTH'(owner)};
            1:       exp = {4'b0000, oh, 1'b0, 2'b11};
            default: exp = {4'b0000, 4'b0000, 1'b0, 2'b11};
         endcase
         obs = {grant, done, forcing, data_out};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL round_robin k%0d got %b exp %b", k, obs, exp);
         end
      end
      req = '0;
      for (int c = 1; c <= 2; c++) begin
         tick;
         exp = (c == 1) ? {4'b0000, 4'b0001, 1'b0, 2'b11} : {4'b0000, 4'b0000, 1'b0, 2'b11};
         obs = {grant, done, forcing, data_out};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL round_robin_end c%0d got %b exp %b", c, obs, exp);
         end
      end
   endtask

   // Duration 0 behaves as 1; pointer is 1 so picking requester 0 also wraps.
   task automatic test_zero_dur;
      logic [10:0] obs, exp;
      a_in = 2'b01; b_in = 2'b00;
      set_req(0, 2'b10, 8'd0);
      req = 4'b0001;
      for (int c = 1; c <= 3; c++) begin
         tick;
         if (c == 1)      exp = {4'b0001, 4'b0000, 1'b1, 2'b10};
         else if (c == 2) exp = {4'b0000, 4'b0001, 1'b0, 2'b01};
         else             exp = {4'b0000, 4'b0000, 1'b0, 2'b01};
         obs = {grant, done, forcing, data_out};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL zero_dur c%0d got %b exp %b", c, obs, exp);
         end
         if (c == 2) req = '0;
      end
   endtask

   // Reset during a window: no done pulse, pointer back to 0.
   task automatic test_reset_mid_force;
      logic [10:0] obs, exp;
      a_in = 2'b10; b_in = 2'b00;
      set_req(2, 2'b01, 8'd5);
      req = 4'b0100;
      for (int c = 1; c <= 6; c++) begin
         tick;
         case (c)
            1, 2:    exp = {4'b0100, 4'b0000, 1'b1, 2'b01};
            3, 4:    exp = 11'b0;
            5:       exp = {4'b0000, 4'b0000, 1'b0, 2'b10};
            default: exp = {4'b0001, 4'b0000, 1'b1, 2'b10};
         endcase
         obs = {grant, done, forcing, data_out};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid c%0d got %b exp %b", c, obs, exp);
         end
         if (c == 2) rst = 1'b1;
         if (c == 4) begin
            rst = 1'b0;
            req = '0;
         end
         if (c == 5) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 2'b10, 8'd1);
            req = 4'b1111;
         end
      end
      req = '0;
      tick;
      tick;
   endtask

   initial begin
      rst = 1'b1; a_in = '0; b_in = '0; req = '0; req_val = '0; req_dur = '0;
      test_reset;
      test_or_path;
      test_force_basic;
      test_abort;
      test_round_robin;
      test_zero_dur;
      test_reset_mid_force;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
